// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin shared 16-bit data memory for NUM_CORES cores; in: clk, rst (async high), start, core_addr/core_wdata/core_we/core_re/core_end; out: core_rdata, core_status, busy, done, addr_err
module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [16*NUM_CORES-1:0] core_addr,
  input  logic [16*NUM_CORES-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES-1:0]    core_re,
  input  logic [NUM_CORES-1:0]    core_end,
  output logic [16*NUM_CORES-1:0] core_rdata,
  output logic [2*NUM_CORES-1:0]  core_status,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_err
);
  localparam int PW = $clog2(NUM_CORES);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] rr_ptr, g;
  logic [NUM_CORES-1:0] halted, halted_nxt, req, gnt;
  logic any, oor, gwe;
  logic [15:0] ga, gwd;
  logic [15:0] mem [2**AW];
  assign busy = state == RUN;
  assign done = state == DONE;
  assign req = (core_we | core_re) & ~halted & {NUM_CORES{busy}};
  assign halted_nxt = halted | (core_end & {NUM_CORES{busy}});
  always_comb begin
    any = 1'b0;
    g = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_CORES]) begin
        any = 1'b1;
        g = PW'((int'(rr_ptr) + k) % NUM_CORES);
      end
    end
  end
  assign gnt = any ? NUM_CORES'(1) << g : '0;
  assign ga = core_addr[16*g +: 16];
  assign gwd = core_wdata[16*g +: 16];
  assign gwe = core_we[g];
  assign oor = (ga >> AW) != 16'd0;
  always_comb begin
    core_status = '0;
    for (int i = 0; i < NUM_CORES; i++)
      core_status[2*i +: 2] = !busy ? (done ? 2'b11 : 2'b00) : halted[i] ? 2'b11 : (req[i] && !gnt[i]) ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      halted <= '0;
      core_rdata <= '0;
      addr_err <= 1'b0;
    end else if (start && !busy) begin
      state <= RUN;
      rr_ptr <= '0;
      halted <= '0;
      addr_err <= 1'b0;
    end else if (busy) begin
      halted <= halted_nxt;
      if (&halted_nxt) state <= DONE;
      if (any) begin
        rr_ptr <= g == PW'(NUM_CORES - 1) ? '0 : g + 1'b1;
        if (oor) addr_err <= 1'b1;
        if (!gwe) core_rdata[16*g +: 16] <= oor ? 16'd0 : mem[ga[AW-1:0]];
      end
    end
  always_ff @(posedge clk)
    if (any && gwe && !oor) mem[ga[AW-1:0]] <= gwd;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Memory-side responder for the multi-core processor data-memory interface: the other end of each core's address / write-data / write-enable / DM-read port.
- Owns a shared single-port data memory and arbitrates NUM_CORES cores round-robin, one access per cycle.
- Drives each core's 2-bit status (run/wait/halt) and collects each core's end_process to report overall completion.

Parameters:
NUM_CORES, 4, number of core ports (2..8)
AW, 8, memory address width; depth = 2**AW words of 16 bits

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a run (honoured in IDLE or DONE only)
core_addr  in  16*NUM_CORES  per-core data address, core i at bits [16i+15:16i]
core_wdata  in  16*NUM_CORES  per-core write data
core_we  in  NUM_CORES  per-core write request
core_re  in  NUM_CORES  per-core read request
core_end  in  NUM_CORES  per-core end_process
core_rdata  out  16*NUM_CORES  per-core read data (DM_out of that core)
core_status  out  2*NUM_CORES  per-core status: 00 IDLE, 01 RUN, 10 WAIT, 11 HALT
busy  out  1  high in RUN
done  out  1  high in DONE
addr_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (async, any state): FSM to IDLE; rr_ptr=0; halted mask=0; all core_rdata=0; core_status=00; busy=0, done=0, addr_err=0. Memory contents not reset (undefined until written).
- FSM states IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(halted mask all ones)--> DONE.
  - DONE --start--> RUN.
  - On entry to RUN: halted mask=0, rr_ptr=0, addr_err=0.
  - start in RUN is ignored.
- Request of core i: req[i] = (core_we[i] | core_re[i]) & ~halted[i] & (state==RUN).
  - core_we wins if both we and re are asserted: the access is a write.
- Arbitration: combinational, one grant per cycle. Search from rr_ptr upward with wrap.
  - After a grant to core g, rr_ptr <= (g+1) mod NUM_CORES.
  - rr_ptr is unchanged when there is no request.
- Granted write: mem[addr[AW-1:0]] <= wdata at the edge.
- Granted read: core_rdata[g] <= mem[addr[AW-1:0]] at the edge, so data is valid the cycle after the grant.
  - core_rdata[g] holds its value until that core's next granted read.
  - A same-cycle read and write cannot occur (single grant).
- Out of range: addr[15:AW] != 0.
  - Access is still granted and consumes the slot.
  - Write is dropped; read returns 0x0000.
  - addr_err <= 1 (sticky until reset or next start).
- core_status[i] (combinational from state/req/grant):
  - IDLE: 00.
  - DONE: 11.
  - RUN: 11 if halted[i]; 10 if req[i] & ~grant[i]; else 01.
  - A core seeing 10 must hold its request unchanged. The request stays pending until granted; the maximum wait is NUM_CORES-1 cycles.
- Halt: core_end[i] sampled high in RUN sets halted[i] at that edge. A request presented in the same cycle as core_end is still arbitrated normally.
- busy = (state==RUN); done = (state==DONE); both registered state decodes.
- core_end and requests are ignored in IDLE and DONE.

Test Plan:
- Reset then start; core0 writes 0xBEEF to addr 0x0010; core1 reads 0x0010 two cycles later -> core_rdata[1]=0xBEEF one cycle after core1's grant; status 01 throughout.
- All 4 cores request every cycle from rr_ptr=0 -> grants 0,1,2,3,0; each non-granted core shows status 10; no core waits more than 3 cycles.
- Core2 reads 0x0100 with AW=8 -> rdata[2]=0x0000, addr_err=1; a write to 0x0100 leaves mem[0x00] unchanged (read back confirms prior value).
- core_end asserted on cores 0..3 in cycles 5,7,7,9 -> each status goes 11 the next cycle; done=1 and busy=0 the cycle after core3's end.
- Core1 asserts core_we and core_re together with wdata 0x1234 -> treated as a write; core_rdata[1] is unchanged.
- rst asserted mid-RUN with pending requests -> all outputs return to reset values immediately; start then resumes with rr_ptr=0, and memory retains the data written before reset.
